// File: rtl/rr_arb_lock.sv
// N-way round-robin arbiter that holds its grant across a packet until the owner's tail beat.
// Zero-latency grant gated by en; define RR_ARB_LOCK_TIMEOUT_EN to add the lock watchdog and timeout_pulse.
module rr_arb_lock #(
  parameter int N       = 8,
  parameter int IW      = $clog2(N),
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  tail,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          locked,
  output logic [IW-1:0] owner
`ifdef RR_ARB_LOCK_TIMEOUT_EN
  ,
  output logic          timeout_pulse
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [IW-1:0] r_own, w_own_nxt;
  logic [IW-1:0] w_win, w_idx, w_sel;
  logic          w_win_vld, w_beat;
  int            w_scan;

  // Wrap explicitly so non-power-of-2 N never lets ptr/own reach N.
  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] x);
    return (x == IW'(N - 1)) ? '0 : x + IW'(1);
  endfunction

  // Scan in reverse rotation order so the last hit is the first requester at/after ptr.
  always_comb begin
    w_win     = '0;
    w_win_vld = 1'b0;
    w_scan    = 0;
    w_idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= N) w_scan = w_scan - N;
      w_idx = IW'(w_scan);
      if (req[w_idx]) begin
        w_win     = w_idx;
        w_win_vld = 1'b1;
      end
    end
  end

  assign w_sel   = (r_state == S_LOCK) ? r_own : w_win;
  assign w_beat  = reset & en & ((r_state == S_LOCK) ? req[r_own] : w_win_vld);
  assign gnt     = w_beat ? (N'(1) << w_sel) : '0;
  assign gnt_idx = w_beat ? w_sel : '0;
  assign locked  = (r_state == S_LOCK);
  assign owner   = locked ? r_own : '0;

`ifdef RR_ARB_LOCK_TIMEOUT_EN
  logic [7:0] r_wdog, w_wdog_nxt;
  logic       w_tmo;
  assign timeout_pulse = w_tmo;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_own_nxt   = r_own;
`ifdef RR_ARB_LOCK_TIMEOUT_EN
    w_wdog_nxt  = r_wdog;
    w_tmo       = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_beat) begin
          if (tail[w_sel]) begin
            w_ptr_nxt = f_inc(w_sel);
          end else begin
            w_state_nxt = S_LOCK;
            w_own_nxt   = w_sel;
`ifdef RR_ARB_LOCK_TIMEOUT_EN
            w_wdog_nxt  = '0;
`endif
          end
        end
      end
      S_LOCK: begin
        if (w_beat) begin
`ifdef RR_ARB_LOCK_TIMEOUT_EN
          w_wdog_nxt = '0;
`endif
          if (tail[w_sel]) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = f_inc(r_own);
          end
        end
`ifdef RR_ARB_LOCK_TIMEOUT_EN
        // This stalled cycle is the TIMEOUT-th in a row: release at this edge.
        else if (r_wdog == 8'(TIMEOUT - 1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = f_inc(r_own);
          w_wdog_nxt  = '0;
        end else begin
          w_wdog_nxt = r_wdog + 8'd1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_own   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_own   <= w_own_nxt;
    end
  end

`ifdef RR_ARB_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_wdog <= '0;
    else        r_wdog <= w_wdog_nxt;
  end
`endif

endmodule

// File: tb/tb_rr_arb_lock.sv
// Bench for rr_arb_lock: an N=8 and an N=5 instance checked every cycle against a packet-level model.
module tb_rr_arb_lock;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req8 = '0, tail8 = '0;
  logic       en8 = 1'b0;
  logic [7:0] gnt8;
  logic [2:0] idx8, own8;
  logic       lck8;
  logic [4:0] req5 = '0, tail5 = '0;
  logic       en5 = 1'b0;
  logic [4:0] gnt5;
  logic [2:0] idx5, own5;
  logic       lck5;
  int         tests = 0;
  int         fails = 0;

  // Model: per instance (0 = N8, 1 = N5) the fairness start point, lock owner and stall count.
  int m_ptr [2];
  int m_own [2];
  int m_wd  [2];
  bit m_lck [2];

`ifdef RR_ARB_LOCK_TIMEOUT_EN
  logic tp8, tp5;
  rr_arb_lock #(.N(8), .TIMEOUT(4)) u8 (.clk(clk), .reset(reset), .req(req8), .tail(tail8), .en(en8),
    .gnt(gnt8), .gnt_idx(idx8), .locked(lck8), .owner(own8), .timeout_pulse(tp8));
  rr_arb_lock #(.N(5)) u5 (.clk(clk), .reset(reset), .req(req5), .tail(tail5), .en(en5),
    .gnt(gnt5), .gnt_idx(idx5), .locked(lck5), .owner(own5), .timeout_pulse(tp5));
`else
  rr_arb_lock #(.N(8), .TIMEOUT(4)) u8 (.clk(clk), .reset(reset), .req(req8), .tail(tail8), .en(en8),
    .gnt(gnt8), .gnt_idx(idx8), .locked(lck8), .owner(own8));
  rr_arb_lock #(.N(5)) u5 (.clk(clk), .reset(reset), .req(req5), .tail(tail5), .en(en5),
    .gnt(gnt5), .gnt_idx(idx5), .locked(lck5), .owner(own5));
`endif

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_tmo_limit(input int u);
    return (u == 0) ? 4 : 16;
  endfunction

  // Who must be granted now (-1 = nobody), from the model state and live inputs.
  function automatic int m_sel(input int u, input int n, input logic [31:0] rq, input bit e);
    if (!reset || !e) return -1;
    if (m_lck[u]) return rq[m_own[u]] ? m_own[u] : -1;
    for (int k = 0; k < n; k++)
      if (rq[(m_ptr[u] + k) % n]) return (m_ptr[u] + k) % n;
    return -1;
  endfunction

  function automatic bit m_tmo(input int u, input int n, input logic [31:0] rq, input bit e);
`ifdef RR_ARB_LOCK_TIMEOUT_EN
    return m_lck[u] && (m_sel(u, n, rq, e) < 0) && (m_wd[u] + 1 == m_tmo_limit(u));
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_step(input int u, input int n, input logic [31:0] rq, input logic [31:0] tl, input bit e);
    int s;
    s = m_sel(u, n, rq, e);
    if (m_tmo(u, n, rq, e)) begin
      m_lck[u] = 1'b0;
      m_ptr[u] = (m_own[u] + 1) % n;
      m_wd[u]  = 0;
    end else if (s >= 0) begin
      m_wd[u] = 0;
      if (tl[s]) begin
        m_lck[u] = 1'b0;
        m_ptr[u] = (s + 1) % n;
      end else if (!m_lck[u]) begin
        m_lck[u] = 1'b1;
        m_own[u] = s;
      end
    end else if (m_lck[u]) begin
      m_wd[u]++;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int u = 0; u < 2; u++) begin
        m_ptr[u] = 0; m_own[u] = 0; m_wd[u] = 0; m_lck[u] = 1'b0;
      end
    end else begin
      m_step(0, 8, 32'(req8), 32'(tail8), en8);
      m_step(1, 5, 32'(req5), 32'(tail5), en5);
    end
  end

  always @(negedge clk) begin
    int s8, s5;
    s8 = m_sel(0, 8, 32'(req8), en8);
    s5 = m_sel(1, 5, 32'(req5), en5);
    check("u8 gnt",     32'(gnt8), (s8 < 0) ? 0 : (1 << s8));
    check("u8 gnt_idx", 32'(idx8), (s8 < 0) ? 0 : s8);
    check("u8 locked",  32'(lck8), 32'(m_lck[0]));
    check("u8 owner",   32'(own8), m_lck[0] ? m_own[0] : 0);
    check("u5 gnt",     32'(gnt5), (s5 < 0) ? 0 : (1 << s5));
    check("u5 gnt_idx", 32'(idx5), (s5 < 0) ? 0 : s5);
    check("u5 locked",  32'(lck5), 32'(m_lck[1]));
    check("u5 owner",   32'(own5), m_lck[1] ? m_own[1] : 0);
`ifdef RR_ARB_LOCK_TIMEOUT_EN
    check("u8 timeout_pulse", 32'(tp8), 32'(m_tmo(0, 8, 32'(req8), en8)));
    check("u5 timeout_pulse", 32'(tp5), 32'(m_tmo(1, 5, 32'(req5), en5)));
`endif
  end

  // Inputs change 1 ns after the rising edge; the call returns at the following falling edge.
  task automatic cyc8(input logic [7:0] r, input logic [7:0] t, input logic e);
    @(posedge clk); #1;
    req8 = r; tail8 = t; en8 = e;
    @(negedge clk);
  endtask

  task automatic cyc5(input logic [4:0] r, input logic [4:0] t, input logic e);
    @(posedge clk); #1;
    req5 = r; tail5 = t; en5 = e;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b0;
    req8 = '0; tail8 = '0; en8 = 1'b0;
    req5 = '0; tail5 = '0; en5 = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
  endtask

  logic [7:0] fair8 [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [4:0] fair5 [6]  = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};

  initial begin
    req8 = 8'hFF; tail8 = 8'hFF; en8 = 1'b1;
    #3;
    check("reset gnt", 32'(gnt8), 32'h0);
    check("reset locked", 32'(lck8), 32'h0);
    check("reset gnt_idx", 32'(idx8), 32'h0);
    req8 = '0; tail8 = '0; en8 = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc8(8'hFF, 8'hFF, 1'b1);
      check("fair gnt", 32'(gnt8), 32'(fair8[i]));
      check("fair locked", 32'(lck8), 32'h0);
    end

    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc8(8'h05, 8'h00, 1'b1);
      check("pkt gnt", 32'(gnt8), 32'h01);
    end
    check("pkt locked", 32'(lck8), 32'h1);
    cyc8(8'h05, 8'h01, 1'b1);
    check("pkt tail gnt", 32'(gnt8), 32'h01);
    cyc8(8'h05, 8'h00, 1'b1);
    check("pkt after tail gnt", 32'(gnt8), 32'h04);
    check("pkt after tail locked", 32'(lck8), 32'h0);

    for (int i = 0; i < 2; i++) begin
      cyc8(8'h20, 8'h00, 1'b1);
      check("bubble gnt", 32'(gnt8), 32'h0);
      check("bubble locked", 32'(lck8), 32'h1);
      check("bubble owner", 32'(own8), 32'h2);
    end
    cyc8(8'h24, 8'h04, 1'b1);
    check("bubble tail gnt", 32'(gnt8), 32'h04);
    cyc8(8'h24, 8'h20, 1'b1);
    check("bubble next gnt", 32'(gnt8), 32'h20);
    check("bubble next idx", 32'(idx8), 32'h5);

    for (int i = 0; i < 2; i++) begin
      cyc8(8'hFF, 8'hFF, 1'b0);
      check("en0 gnt", 32'(gnt8), 32'h0);
    end
    cyc8(8'hFF, 8'hFF, 1'b1);
    check("en resume gnt", 32'(gnt8), 32'h40);

    do_reset();
    cyc8(8'h08, 8'h00, 1'b1);
    cyc8(8'h08, 8'h00, 1'b1);
    check("pre-reset owner", 32'(own8), 32'h3);
    #2;
    reset = 1'b0;
    req8 = 8'hFF; tail8 = 8'hFF;
    #1;
    check("async reset gnt", 32'(gnt8), 32'h0);
    check("async reset locked", 32'(lck8), 32'h0);
    check("async reset owner", 32'(own8), 32'h0);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("post-reset gnt", 32'(gnt8), 32'h01);
    cyc8(8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 6; i++) begin
      cyc5(5'h1F, 5'h1F, 1'b1);
      check("n5 fair gnt", 32'(gnt5), 32'(fair5[i]));
    end
    cyc5(5'h10, 5'h00, 1'b1);
    check("n5 lock gnt", 32'(gnt5), 32'h10);
    cyc5(5'h10, 5'h10, 1'b1);
    check("n5 lock owner", 32'(own5), 32'h4);
    cyc5(5'h1F, 5'h1F, 1'b1);
    check("n5 wrap gnt", 32'(gnt5), 32'h01);
    cyc5(5'h00, 5'h00, 1'b0);

`ifdef RR_ARB_LOCK_TIMEOUT_EN
    do_reset();
    cyc8(8'h02, 8'h00, 1'b1);
    check("tmo first gnt", 32'(gnt8), 32'h02);
    for (int i = 0; i < 4; i++) begin
      cyc8(8'h40, 8'h00, 1'b1);
      check("tmo stall gnt", 32'(gnt8), 32'h0);
      check("tmo pulse", 32'(tp8), (i == 3) ? 32'h1 : 32'h0);
    end
    cyc8(8'h40, 8'h40, 1'b1);
    check("tmo next gnt", 32'(gnt8), 32'h40);
    check("tmo next locked", 32'(lck8), 32'h0);
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/rr_arb_lock.md
Name: rr_arb_lock

Overview:
- Parametrised N-way round-robin arbiter with packet lock, used at each router output port to select among input VCs/ports.
- Successor to the fixed 8-way arbiter; channel count is generic.
- Holds a grant across a multi-flit packet until the owner signals its tail flit, then releases and advances the fairness pointer.
- Optional lock watchdog forces release of a stalled owner.

Parameters:
- N, 8, number of requesters (2..32, need not be a power of 2)
- IW, $clog2(N), index width (derived; do not override)
- TIMEOUT, 16, watchdog limit in cycles; used only with the optional feature (1..255)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- req  in  N  per-requester request; held high for every flit of a packet
- tail  in  N  per-requester tail marker; qualifies the current flit as the last one
- en  in  1  downstream accept this cycle; a beat transfers when gnt[i] is high
- gnt  out  N  one-hot grant; a beat transfers when gnt[i]=1
- gnt_idx  out  IW  binary index of the current grant; 0 when gnt=0
- locked  out  1  arbiter is holding an owner (LOCK state)
- owner  out  IW  locked owner index; 0 in IDLE

Behaviour:
- State: fsm {IDLE, LOCK}, ptr[IW-1:0], own[IW-1:0], optional wdog counter.
- Reset (reset=0, asynchronous): fsm=IDLE, ptr=0, own=0, wdog=0.
  - While reset=0, gnt=0, gnt_idx=0, locked=0 and owner=0, regardless of req/en.
  - Reset asserted mid-packet abandons the lock immediately.
- IDLE, grant selection (combinational):
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - gnt=onehot(winner) when en=1 and |req=1; otherwise gnt=0.
- IDLE, on a beat (gnt≠0) at the clock edge:
  - tail[winner]=1 (single-flit packet): stay IDLE; ptr=winner+1, wrapping to 0 when winner=N-1.
  - tail[winner]=0: go to LOCK, own=winner; ptr unchanged.
- IDLE, no beat: no state change; ptr holds.
- LOCK, grant (combinational):
  - gnt=onehot(own) iff en=1 and req[own]=1; otherwise gnt=0.
  - Other requesters are never granted in LOCK, even if req[own]=0 (bubble, lock retained).
- LOCK, beat with tail[own]=1: go to IDLE; ptr=own+1 with the same wrap rule. Winner changes on the next cycle.
- LOCK, beat with tail[own]=0: remain in LOCK.
- tail bits for non-granted requesters are ignored.
- Zero-latency arbitration: grant appears in the same cycle as req/en. Earliest possible grant to a different requester is the cycle after a tail beat.
- Simultaneous events:
  - req and tail change freely between cycles; only values at the beat edge matter.
  - en=0 freezes ptr, fsm and own.
- Non-power-of-2 N: ptr and own must never reach values ≥ N; the wrap from N-1 goes to 0.
- Outputs:
  - locked=(fsm==LOCK).
  - owner=own when locked, else 0.
  - gnt_idx=binary(gnt).

Optional Feature:
- Macro: RR_ARB_LOCK_TIMEOUT_EN.
- Defined:
  - 8-bit wdog clears on entry to LOCK and on every beat.
  - wdog increments each LOCK cycle with no beat.
  - When wdog reaches TIMEOUT, force fsm=IDLE and ptr=own+1 (wrapped) at that edge, with no beat that cycle. Arbitration resumes from IDLE on the next cycle.
  - Adds output timeout_pulse (1 bit), high for the single cycle in which the forced release occurs; 0 in reset.
- Not defined: no wdog register and no timeout_pulse port; a lock persists until a tail beat or reset.

Test Plan:
- Single-flit fairness, N=8: req=8'hFF, tail=8'hFF, en=1 for 10 cycles → gnt=0x01,0x02,…,0x80,0x01,0x02; locked stays 0.
- Packet lock: req=0x05, tail=0; 3 beats granted to idx 0; then tail[0]=1 → 4th beat to idx 0, next cycle gnt=0x04, ptr=1.
- Bubble in lock: owner=2 (N=8), req[2] drops for 2 cycles while req[5]=1 → gnt=0 both cycles, locked=1; req[2] returns with tail=1 → grant idx2; next cycle gnt=0x20.
- Non-power-of-2, N=5: req=5'b11111, single-flit → grant order 0,1,2,3,4,0; ptr never ≥5. Lock on idx4 then tail → ptr=0.
- Backpressure and async reset: en=0 with req=0xFF → gnt=0 and ptr frozen. Mid-packet (owner=3) drive reset=0 between clock edges → gnt=0 and locked=0 immediately; after release, first grant goes to idx0.
- With RR_ARB_LOCK_TIMEOUT_EN, TIMEOUT=4: owner=1 drops req after 1 beat, req[6]=1 → timeout_pulse on the 4th stalled cycle; next cycle gnt=0x40.
